antic_dma_arbiter: RTL

- Owns the shared system address bus on behalf of the ANTIC graphics processor.
- Arbitrates among display-list fetch, player-missile fetch, playfield/character fetch and an internal DRAM-refresh requester.
- Halts the 6502 before stealing cycles, drives the granted requester's address and returns a data-valid strobe.
- Sits between the ANTIC fetch FSM/dataTranslate logic and the CPU RDY/address-bus mux.

---
 rtl/antic_dma_if.sv | 23 ++
 rtl/antic_dma_arbiter.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/antic_dma_if.sv
// ANTIC DMA arbiter bus bundle: requester side in, grant/halt/refresh side out.
// The tri-stated system address stays a plain port on the arbiter.
interface antic_dma_if;
  logic        dma_en;
  logic [3:0]  req;
  logic [63:0] req_addr;
  logic        cpu_rw;
  logic [3:0]  gnt;
  logic [3:0]  data_valid;
  logic        addr_en;
  logic        halt;
  logic        refresh_l;
  logic [7:0]  refresh_missed;

  modport master (
    input  dma_en, req, req_addr, cpu_rw,
    output gnt, data_valid, addr_en, halt, refresh_l, refresh_missed
  );
  modport slave (
    output dma_en, req, req_addr, cpu_rw,
    input  gnt, data_valid, addr_en, halt, refresh_l, refresh_missed
  );
endinterface

// File: rtl/antic_dma_arbiter.sv
// ANTIC system-bus DMA arbiter: halts the 6502, grants fixed-priority fetches
// in bounded bursts, and slots in one DRAM refresh per scanline.
module antic_dma_arbiter #(
  parameter int MAX_BURST      = 8,
  parameter int REFRESH_PERIOD = 114,
  parameter int HALT_LEAD      = 1
) (
  input  logic         clk,
  input  logic         rst,
  antic_dma_if.master  bus,
  output logic [15:0]  address
);

  localparam int RC_W = $clog2(REFRESH_PERIOD);
  localparam int BU_W = $clog2(MAX_BURST + 1);
  localparam int LD_W = (HALT_LEAD > 1) ? $clog2(HALT_LEAD) : 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(REFRESH_PERIOD - 1);
  localparam logic [BU_W-1:0] BU_MAX  = BU_W'(MAX_BURST);
  localparam logic [LD_W-1:0] LD_LAST = LD_W'(HALT_LEAD - 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] HALTREQ = 3'd1;
  localparam logic [2:0] GRANT   = 3'd2;
  localparam logic [2:0] NEXT    = 3'd3;
  localparam logic [2:0] RELEASE = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [BU_W-1:0] burst_q, burst_d;
  logic [LD_W-1:0] lead_q, lead_d;
  logic [RC_W-1:0] rc_q, rc_d;
  logic            pend_q, pend_d;
  logic [7:0]      missed_q, missed_d;
  logic [3:0]      dv_q, dv_d;

  logic [3:0]  req_m, win, gnt;
  logic [15:0] win_addr;
  logic        any_req, work, rc_wrap, serve_ref, drive_addr;
  logic        addr_en, halt, refresh_l;

  assign req_m   = bus.req & {4{bus.dma_en}};
  assign any_req = |req_m;
  assign work    = any_req | pend_q;

  // Walk from lowest priority up so the highest-priority requester wins.
  always_comb begin
    win      = '0;
    win_addr = '0;
    for (int i = 3; i >= 0; i--) begin
      if (req_m[i]) begin
        win      = 4'(1 << i);
        win_addr = bus.req_addr[16*i +: 16];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    burst_d    = burst_q;
    lead_d     = lead_q;
    gnt        = '0;
    addr_en    = 1'b0;
    halt       = 1'b0;
    refresh_l  = 1'b1;
    serve_ref  = 1'b0;
    drive_addr = 1'b0;
    case (state_q)
      IDLE: begin
        lead_d = '0;
        if (work) state_d = HALTREQ;
      end
      HALTREQ: begin
        halt = 1'b1;
        // Lead time first, then wait out any CPU write cycles.
        if (lead_q >= LD_LAST) begin
          if (bus.cpu_rw) state_d = GRANT;
        end else begin
          lead_d = lead_q + 1'b1;
        end
      end
      GRANT: begin
        halt       = 1'b1;
        addr_en    = 1'b1;
        gnt        = win;
        drive_addr = any_req;
        serve_ref  = ~any_req & pend_q;
        refresh_l  = ~serve_ref;
        burst_d    = burst_q + 1'b1;
        state_d    = NEXT;
      end
      NEXT: begin
        halt    = 1'b1;
        state_d = (work && burst_q < BU_MAX) ? GRANT : RELEASE;
      end
      RELEASE: begin
        burst_d = '0;
        lead_d  = '0;
        state_d = work ? HALTREQ : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Refresh counter free-runs; a wrap with a refresh still owed is a miss.
  always_comb begin
    rc_wrap  = (rc_q == RC_LAST);
    rc_d     = rc_wrap ? '0 : rc_q + 1'b1;
    pend_d   = rc_wrap | (pend_q & ~serve_ref);
    missed_d = (rc_wrap && pend_q && missed_q != 8'hFF) ? missed_q + 8'd1 : missed_q;
    dv_d     = gnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      burst_q  <= '0;
      lead_q   <= '0;
      rc_q     <= '0;
      pend_q   <= 1'b0;
      missed_q <= '0;
      dv_q     <= '0;
    end else begin
      state_q  <= state_d;
      burst_q  <= burst_d;
      lead_q   <= lead_d;
      rc_q     <= rc_d;
      pend_q   <= pend_d;
      missed_q <= missed_d;
      dv_q     <= dv_d;
    end
  end

  assign bus.gnt            = gnt;
  assign bus.data_valid     = dv_q;
  assign bus.addr_en        = addr_en;
  assign bus.halt           = halt;
  assign bus.refresh_l      = refresh_l;
  assign bus.refresh_missed = missed_q;
  assign address            = drive_addr ? win_addr : 16'hzzzz;

endmodule
